// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared widths, requester count and port FSM states for the register-port arbiter
//
// Purpose : common definitions imported by reg_arb_port and reg_port_arb.
// Contents: REG_DW   - default register data width
//           REG_AW   - default register address width (8 registers)
//           NUM_REQ  - number of requesters sharing the register-file port
//           port_state_e - per-requester FSM states {IDLE, RSP_PEND}

package reg_arb_pkg;

    localparam int REG_DW  = 16;
    localparam int REG_AW  = 3;
    localparam int NUM_REQ = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        RSP_PEND = 1'b1
    } port_state_e;

endpackage

// File: rtl/reg_arb_port.sv
// rtl/reg_arb_port.sv - per-requester response FSM and read-data register
//
// Purpose : tracks whether a read response is outstanding for one requester and
//           holds the captured read data until the requester accepts it.
// Ports   : Clk        - clock, rising edge
//           Reset      - synchronous, active-high
//           rd_hs      - read handshake for this requester this cycle
//           rd_data    - register-file read data to capture on rd_hs
//           rsp_ready  - requester accepts the response
//           rsp_valid  - response outstanding (also blocks further grants)
//           rsp_rdata  - captured read data, stable while rsp_valid

module reg_arb_port
    import reg_arb_pkg::*;
#(
    parameter int DW = REG_DW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          rd_hs,
    input  logic [DW-1:0] rd_data,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata
);

    port_state_e   state_q;
    port_state_e   state_d;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rd_hs)     state_d = RSP_PEND;
            RSP_PEND: if (rsp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // The arbiter never grants a requester in RSP_PEND, so rd_hs only occurs
    // from IDLE and the captured data cannot change while the response waits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (rd_hs) begin
            rdata_q <= rd_data;
        end
    end

    assign rsp_valid = (state_q == RSP_PEND);
    assign rsp_rdata = rdata_q;

endmodule

// File: rtl/reg_port_arb.sv
// rtl/reg_port_arb.sv - two-requester arbiter in front of a single register-file port
//
// Purpose : grants at most one requester per cycle onto the register-file
//           write/read select lines; writes complete at the grant edge, reads
//           return data one cycle after the grant through reg_arb_port.
// Macro   : REG_ARB_RR_EN - defined: round-robin arbitration;
//                           undefined: fixed priority, requester 0 wins.
// Ports   : Clk, Reset               - clock and synchronous active-high reset
//           req_valid/req_ready      - per-requester request handshake
//           req_we/req_addr/req_wdata - per-requester command fields
//           rsp_valid/rsp_ready/rsp_rdata - per-requester read response
//           rf_dr/rf_ld/rf_busresult - register-file write select/enable/data
//           rf_sr1/rf_sr1_out        - register-file read select/combinational data

module reg_port_arb
    import reg_arb_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0][AW-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][DW-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [NUM_REQ-1:0][DW-1:0]    rsp_rdata,
    output logic [AW-1:0]                 rf_dr,
    output logic [AW-1:0]                 rf_sr1,
    output logic                          rf_ld,
    output logic [DW-1:0]                 rf_busresult,
    input  logic [DW-1:0]                 rf_sr1_out
);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rd_hs;
    logic               sel;

    // A requester with a response outstanding stays ineligible through the
    // accept cycle, since rsp_valid only drops at the following edge.
    assign eligible = req_valid & ~rsp_valid & {NUM_REQ{~Reset}};

`ifdef REG_ARB_RR_EN
    logic rr_ptr;

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer favours the requester that was not served.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr <= 1'b0;
        end else if (|grant) begin
            rr_ptr <= grant[0];
        end
    end
`else
    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant = 2'b01;
        end
    end
`endif

    assign req_ready = grant;
    assign sel       = grant[1];

    always_comb begin
        rf_ld        = 1'b0;
        rf_dr        = '0;
        rf_sr1       = '0;
        rf_busresult = '0;
        rd_hs        = '0;
        if (|grant) begin
            if (req_we[sel]) begin
                rf_ld        = 1'b1;
                rf_dr        = req_addr[sel];
                rf_busresult = req_wdata[sel];
            end else begin
                rf_sr1     = req_addr[sel];
                rd_hs[sel] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        reg_arb_port #(
            .DW (DW)
        ) u_port (
            .Clk       (Clk),
            .Reset     (Reset),
            .rd_hs     (rd_hs[i]),
            .rd_data   (rf_sr1_out),
            .rsp_ready (rsp_ready[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp_rdata (rsp_rdata[i])
        );
    end

endmodule
